// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register-file hazard scoreboard for the decode stage. It keeps one busy bit
// per architectural register. A writing instruction sets the bit when it
// issues, and writeback clears it. Decode is stalled on RAW and WAW hazards
// against busy registers. The block has no datapath: it only gates the issue
// handshake and keeps stall and occupancy statistics for performance debug.
//
// Optional feature (macro REG_SB_WB_BYPASS_EN):
//   defined   - a register being written back this cycle counts as not busy
//               for the hazard check, because the register file forwards the
//               write. A dependent instruction then issues in the writeback
//               cycle.
//   undefined - hazards are read only from the registered busy bits.
//
// Parameters:
//   NREG      number of architectural registers (register 0 is hard zero)
//   REGADDR   register address width, 2**REGADDR == NREG
//   CNTW      stall counter width
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   iss_valid           decode holds a valid instruction
//   iss_rs / iss_rt     source registers
//   iss_use_rs/_rt      instruction reads the matching source register
//   iss_wr / iss_dst    instruction writes iss_dst
//   iss_ready           combinational issue permission
//   wb_valid / wb_reg   writeback writes wb_reg this cycle
//   flush               synchronous pipeline flush (clears all busy bits)
//   busy_vec            registered busy bits (bit 0 always 0)
//   busy_cnt            registered popcount of busy_vec
//   stall_cnt           saturating count of stalled cycles
//   wb_err              sticky: writeback to a register that was not busy
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int REGADDR = 5,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_valid,
    input  logic [REGADDR-1:0] iss_rs,
    input  logic [REGADDR-1:0] iss_rt,
    input  logic               iss_use_rs,
    input  logic               iss_use_rt,
    input  logic               iss_wr,
    input  logic [REGADDR-1:0] iss_dst,
    output logic               iss_ready,
    input  logic               wb_valid,
    input  logic [REGADDR-1:0] wb_reg,
    input  logic               flush,
    output logic [NREG-1:0]    busy_vec,
    output logic [REGADDR:0]   busy_cnt,
    output logic [CNTW-1:0]    stall_cnt,
    output logic               wb_err
);

    localparam logic [CNTW-1:0] STALL_MAX = {CNTW{1'b1}};

    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;
    logic [NREG-1:0]    hazard_vec;
    logic [REGADDR:0]   cnt_d;
    logic               wb_live;
    logic               iss_fire;
    logic               stall_now;
    logic               wb_err_now;

    // A writeback to register 0 is architecturally meaningless. It neither
    // clears anything nor raises wb_err.
    assign wb_live = wb_valid && (wb_reg != '0);

    // Busy bits as seen by the hazard check. Bit 0 is never set in busy_q, so
    // register 0 can never cause a stall.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first,
        // so that no path through the block leaves it unassigned (a latch).
        hazard_vec = busy_q;
`ifdef REG_SB_WB_BYPASS_EN
        if (wb_valid) begin
            hazard_vec[wb_reg] = 1'b0;
        end
`endif
    end

    assign iss_ready = !flush
                    && !(iss_use_rs && hazard_vec[iss_rs])
                    && !(iss_use_rt && hazard_vec[iss_rt])
                    && !(iss_wr     && hazard_vec[iss_dst]);

    assign iss_fire   = iss_valid && iss_ready;
    assign stall_now  = iss_valid && !iss_ready && !flush;
    assign wb_err_now = wb_live && !busy_q[wb_reg] && !flush;

    // Next busy state. The clear is applied before the set, so that a new
    // producer issuing to the register being written back keeps ownership.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_live) begin
                busy_d[wb_reg] = 1'b0;
            end
            if (iss_fire && iss_wr && (iss_dst != '0)) begin
                busy_d[iss_dst] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // busy_cnt is registered from the next busy vector, so it tracks busy_vec
    // on the same edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{REGADDR{1'b0}}, busy_d[i]};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            busy_cnt  <= '0;
            stall_cnt <= '0;
            wb_err    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
            if (stall_now && (stall_cnt != STALL_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (wb_err_now) begin
                wb_err <= 1'b1;
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Scoreboard bench for reg_scoreboard. The driver applies one cycle of
// stimulus, asks a behavioural model for the expected response (issue
// permission plus the registered outputs), and queues it. A monitor on the
// falling edge pops each entry and compares it against the DUT. Directed
// sequences follow the documented scenarios, and then a randomized phase runs.
// CNTW is 4, so stall counter saturation is reached quickly.
// Build with +define+REG_SB_WB_BYPASS_EN to check the bypass variant.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int NREG = 32;
    localparam int RA   = 5;
    localparam int CNTW = 4;
    localparam int SMAX = (1 << CNTW) - 1;
`ifdef REG_SB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            iss_valid;
    logic [RA-1:0]   iss_rs;
    logic [RA-1:0]   iss_rt;
    logic            iss_use_rs;
    logic            iss_use_rt;
    logic            iss_wr;
    logic [RA-1:0]   iss_dst;
    logic            iss_ready;
    logic            wb_valid;
    logic [RA-1:0]   wb_reg;
    logic            flush;
    logic [NREG-1:0] busy_vec;
    logic [RA:0]     busy_cnt;
    logic [CNTW-1:0] stall_cnt;
    logic            wb_err;

    reg_scoreboard #(.NREG(NREG), .REGADDR(RA), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid  (iss_valid),
        .iss_rs     (iss_rs),
        .iss_rt     (iss_rt),
        .iss_use_rs (iss_use_rs),
        .iss_use_rt (iss_use_rt),
        .iss_wr     (iss_wr),
        .iss_dst    (iss_dst),
        .iss_ready  (iss_ready),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .flush      (flush),
        .busy_vec   (busy_vec),
        .busy_cnt   (busy_cnt),
        .stall_cnt  (stall_cnt),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ready;
        logic [31:0] busy;
        int          cnt;
        int          stall;
        bit          err;
    } exp_t;

    exp_t expq[$];

    // Reference state: the set of pending producers, stall total and error flag.
    bit m_busy[NREG];
    int m_stall;
    bit m_err;

    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_stall = 0;
        m_err   = 1'b0;
    endfunction

    // A register blocks decode if it has a pending producer, unless that
    // producer is writing back right now and the register file forwards it.
    function automatic bit m_blocked(input int r, input bit wbv, input int wbr);
        if (r == 0) return 1'b0;
        if (BYPASS && wbv && wbr == r) return 1'b0;
        return m_busy[r];
    endfunction

    // One cycle: drive the inputs, queue the expected response, advance the model.
    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input int dst, input bit wbv, input int wbr, input bit fl);
        exp_t e;
        bit   rdy;
        iss_valid  = v;
        iss_rs     = RA'(rs);
        iss_rt     = RA'(rt);
        iss_use_rs = urs;
        iss_use_rt = urt;
        iss_wr     = wr;
        iss_dst    = RA'(dst);
        wb_valid   = wbv;
        wb_reg     = RA'(wbr);
        flush      = fl;

        rdy = !fl && !(urs && m_blocked(rs, wbv, wbr)) && !(urt && m_blocked(rt, wbv, wbr))
                  && !(wr && m_blocked(dst, wbv, wbr));
        e.ready = rdy;
        e.busy  = m_vec();
        e.cnt   = m_count();
        e.stall = m_stall;
        e.err   = m_err;
        expq.push_back(e);

        if (fl) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else begin
            if (wbv && wbr != 0) begin
                if (!m_busy[wbr]) m_err = 1'b1;
                m_busy[wbr] = 1'b0;
            end
            if (v && rdy && wr && dst != 0) m_busy[dst] = 1'b1;
            if (v && !rdy && m_stall < SMAX) m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops and compares one expected response per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("iss_ready", 64'(iss_ready), 64'(e.ready));
                check("busy_vec",  64'(busy_vec),  64'(e.busy));
                check("busy_cnt",  64'(busy_cnt),  64'(e.cnt));
                check("stall_cnt", 64'(stall_cnt), 64'(e.stall));
                check("wb_err",    64'(wb_err),    64'(e.err));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_reset();
        rst_n      = 1'b0;
        iss_valid  = 1'b0;
        iss_rs     = '0;
        iss_rt     = '0;
        iss_use_rs = 1'b0;
        iss_use_rt = 1'b0;
        iss_wr     = 1'b0;
        iss_dst    = '0;
        wb_valid   = 1'b0;
        wb_reg     = '0;
        flush      = 1'b0;

        #2;
        check("reset_ready",    64'(iss_ready), 64'd1);
        check("reset_busy_vec", 64'(busy_vec),  64'd0);
        check("reset_busy_cnt", 64'(busy_cnt),  64'd0);
        check("reset_stall",    64'(stall_cnt), 64'd0);
        check("reset_wb_err",   64'(wb_err),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic issue of a writer to r5.
        step(1, 3, 4, 1, 1, 1, 5, 0, 0, 0);
        check("issue_r5_busy_vec", 64'(busy_vec), 64'h20);
        check("issue_r5_busy_cnt", 64'(busy_cnt), 64'd1);

        // RAW on r5: stall, then writeback releases it.
        repeat (3) step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 1, 5, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        check("raw_release_busy_vec", 64'(busy_vec), 64'd0);

        // WAW on r7. Ends with r7 owned by the new producer in both builds.
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        if (!BYPASS) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        check("waw_r7_owned", 64'(busy_vec), 64'h80);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

        // Register 0 never becomes busy and never raises wb_err.
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        check("r0_busy_vec", 64'(busy_vec), 64'd0);
        check("r0_wb_err",   64'(wb_err),   64'd0);

        // Flush has priority over a simultaneous issue and writeback.
        step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 4, 1, 2, 1);
        check("flush_busy_vec", 64'(busy_vec), 64'd0);
        check("flush_busy_cnt", 64'(busy_cnt), 64'd0);
        check("flush_wb_err",   64'(wb_err),   64'd0);

        // Writeback to a register that is not busy sets the sticky error.
        step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        check("wb_err_set", 64'(wb_err), 64'd1);
        repeat (2) idle();
        check("wb_err_sticky", 64'(wb_err), 64'd1);

        // Stall counter saturation.
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        repeat (20) step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        check("stall_saturated", 64'(stall_cnt), 64'(SMAX));

        // Asynchronous reset in the middle of a stall.
        iss_valid  = 1'b1;
        iss_rs     = RA'(5);
        iss_use_rs = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready",    64'(iss_ready), 64'd1);
        check("async_rst_busy_vec", 64'(busy_vec),  64'd0);
        check("async_rst_busy_cnt", 64'(busy_cnt),  64'd0);
        check("async_rst_stall",    64'(stall_cnt), 64'd0);
        check("async_rst_wb_err",   64'(wb_err),    64'd0);
        m_reset();
        iss_valid  = 1'b0;
        iss_use_rs = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized phase. Small register numbers produce frequent hazards, and
        // writebacks usually target a register that really is pending.
        for (int n = 0; n < 1500; n++) begin
            int pend[$];
            int wbr;
            bit wbv;
            for (int i = 1; i < NREG; i++) if (m_busy[i]) pend.push_back(i);
            wbv = ($urandom_range(0, 99) < 40);
            if (pend.size() > 0 && $urandom_range(0, 99) < 85)
                wbr = pend[$urandom_range(0, pend.size() - 1)];
            else
                wbr = $urandom_range(0, 31);
            step($urandom_range(0, 99) < 75,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 9),
                 wbv, wbr,
                 $urandom_range(0, 99) < 3);
        end

        idle();
        @(negedge clk);
        #1;
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file hazard scoreboard that sits beside the ID stage register file and decides, each cycle, whether the instruction in decode may issue. It tracks one busy bit per architectural register (set at issue by a writing instruction, cleared at writeback), stalls decode on RAW and WAW hazards, and keeps stall and occupancy statistics for performance debug. It has no datapath; it gates the issue handshake only.

## Interface
- NREG, 32: number of architectural registers; register 0 is hard-wired zero.
- REGADDR, 5: register address width; must satisfy 2^REGADDR = NREG.
- CNTW, 16: stall counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iss_valid  in  1  decode holds a valid instruction.
- iss_rs  in  REGADDR  source register 1 (ir[25:21]).
- iss_rt  in  REGADDR  source register 2 (ir[20:16]).
- iss_use_rs  in  1  instruction reads iss_rs.
- iss_use_rt  in  1  instruction reads iss_rt.
- iss_wr  in  1  instruction writes a register.
- iss_dst  in  REGADDR  destination register (rt or rd, already selected).
- iss_ready  out  1  combinational; issue permitted this cycle.
- wb_valid  in  1  writeback stage writes the register file this cycle (reg_wrt).
- wb_reg  in  REGADDR  writeback destination.
- flush  in  1  synchronous pipeline flush.
- busy_vec  out  NREG  registered busy bits; bit 0 always 0.
- busy_cnt  out  REGADDR+1  registered count of set busy bits.
- stall_cnt  out  CNTW  saturating count of stalled cycles.
- wb_err  out  1  sticky; writeback to a non-busy register seen.

## Operation
- Hazard: src_hit(r) = busy[r] and r != 0 (see Configuration for writeback bypass).
- iss_ready = not flush and not (iss_use_rs and src_hit(iss_rs)) and not (iss_use_rt and src_hit(iss_rt)) and not (iss_wr and src_hit(iss_dst)).
- Issue fires when iss_valid and iss_ready: if iss_wr and iss_dst != 0, busy[iss_dst] set next edge.
- Writeback: wb_valid and wb_reg != 0 clears busy[wb_reg] next edge; if busy[wb_reg] was 0, wb_err set (stays set until reset).
- Same register set by issue and cleared by writeback in one cycle: set wins (new producer owns it).
- flush: all busy bits cleared next edge; has priority over issue and writeback; wb_err not evaluated in a flush cycle; stall_cnt not incremented.
- Register 0: never busy, never stalls, wb to 0 ignored (no wb_err).
- busy_cnt equals popcount of next busy_vec, updated same edge.
- stall_cnt increments on each cycle with iss_valid and not iss_ready; saturates at 2^CNTW-1.

## Timing
- Reset values: busy_vec 0, busy_cnt 0, stall_cnt 0, wb_err 0; iss_ready 1 while rst_n low or immediately after (nothing busy, flush low).
- iss_ready: zero-cycle combinational path from iss_*, wb_*, flush and busy state.
- Busy set/clear: visible on busy_vec and in iss_ready one cycle after the issue/writeback edge.
- Reset asserted mid-operation clears all state asynchronously; pending producers are forgotten.
- iss_valid low: iss_ready still computed, no state change, no stall counted.

## Configuration
- REG_SB_WB_BYPASS_EN defined: a source or destination matching wb_reg while wb_valid is treated as not busy in the same cycle (register file forwards the write), so a dependent instruction issues in the writeback cycle.
- Undefined: busy is read only from the registered bits; a dependent instruction stalls through the writeback cycle and issues one cycle later.

## Test plan
- Reset, then iss_valid with rs=3, rt=4, wr dst=5 -> iss_ready=1, busy_vec=0x20, busy_cnt=1 next cycle.
- With r5 busy, issue reading rs=5 -> iss_ready=0, stall_cnt increments each cycle; wb_valid wb_reg=5 -> with bypass issue same cycle, without bypass next cycle; busy_vec returns 0.
- WAW: r7 busy, issue wr dst=7 -> stalled until writeback of r7; with bypass, same-cycle wb+issue leaves busy[7]=1.
- Issue wr dst=0 and read rs=0 with wb to 0 -> iss_ready=1, busy_vec stays 0, wb_err stays 0.
- r2, r9 busy, flush with simultaneous issue dst=4 and wb_reg=2 -> iss_ready=0, next cycle busy_vec=0, busy_cnt=0, wb_err=0.
- wb_valid wb_reg=12 with r12 not busy -> wb_err=1 and remains 1; force stall_cnt to saturate (CNTW=4, 20 stalled cycles) -> holds 15; assert rst_n low mid-stall -> all outputs to reset values immediately.
